// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with frame-boundary shadowed timing registers
// Ports: clk/reset_n are the clock and the asynchronous active-low reset.
//   cfg_we/cfg_addr/cfg_wdata write the shadow registers (0-3 horizontal display/front/sync/back,
//   4-7 vertical display/bottom/sync/top); cfg_pending flags a write not yet applied.
//   pix_tick is the pixel-rate enable. hpos/vpos, hsync/vsync, display_on, line_start/frame_start
//   and frame_count describe the pixel currently presented.
module video_timing_gen #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int CW = 12,
  parameter int PIX_DIV = 1,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT = 7,
  parameter int H_SYNC = 23,
  parameter int H_BACK = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM = 14,
  parameter int V_SYNC = 4,
  parameter int V_TOP = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  output logic          cfg_pending,
  output logic          pix_tick,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [3:0][HW-1:0] H_INIT = {HW'(H_BACK), HW'(H_SYNC), HW'(H_FRONT), HW'(H_DISPLAY)};
  localparam logic [3:0][VW-1:0] V_INIT = {VW'(V_TOP), VW'(V_SYNC), VW'(V_BOTTOM), VW'(V_DISPLAY)};
  logic [DW-1:0] div;
  logic tick;
  logic primed;
  logic wrap;
  logic hs_on;
  logic vs_on;
  logic de;
  logic [3:0][HW-1:0] sh_h;
  logic [3:0][HW-1:0] act_h;
  logic [3:0][HW-1:0] na_h;
  logic [3:0][VW-1:0] sh_v;
  logic [3:0][VW-1:0] act_v;
  logic [3:0][VW-1:0] na_v;
  logic [HW-1:0] h_max;
  logic [HW-1:0] nh;
  logic [HW-1:0] hs_s;
  logic [HW-1:0] hs_e;
  logic [VW-1:0] v_max;
  logic [VW-1:0] nv;
  logic [VW-1:0] vs_s;
  logic [VW-1:0] vs_e;
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;
  assign tick = div == DW'(PIX_DIV - 1);
  // Everything is computed for the position about to be presented, so sync/display
  // registers alongside hpos/vpos with no lag. At the frame wrap the shadow values
  // already govern the new (0,0) pixel.
  always_comb begin
    h_max = act_h[0] + act_h[1] + act_h[2] + act_h[3] - HW'(1);
    v_max = act_v[0] + act_v[1] + act_v[2] + act_v[3] - VW'(1);
    wrap = primed && hpos == h_max && vpos == v_max;
    nh = (!primed || hpos == h_max) ? '0 : hpos + HW'(1);
    nv = (!primed || wrap) ? '0 : hpos == h_max ? vpos + VW'(1) : vpos;
    na_h = wrap ? sh_h : act_h;
    na_v = wrap ? sh_v : act_v;
    hs_s = na_h[0] + na_h[1];
    hs_e = hs_s + na_h[2] - HW'(1);
    vs_s = na_v[0] + na_v[1];
    vs_e = vs_s + na_v[2] - VW'(1);
    hs_on = na_h[2] != '0 && nh >= hs_s && nh <= hs_e;
    vs_on = na_v[2] != '0 && nv >= vs_s && nv <= vs_e;
    de = nh < na_h[0] && nv < na_v[0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      pix_tick <= 1'b0;
      primed <= 1'b0;
      sh_h <= H_INIT;
      act_h <= H_INIT;
      sh_v <= V_INIT;
      act_v <= V_INIT;
      hpos <= '0;
      vpos <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      display_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      cfg_pending <= 1'b0;
      frame_count <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      pix_tick <= tick;
      line_start <= tick && (!primed || hpos == h_max);
      frame_start <= tick && (!primed || wrap);
      // A write coinciding with the apply keeps the flag set: it only reached the shadow.
      cfg_pending <= cfg_we || (cfg_pending && !(tick && wrap));
      if (cfg_we && cfg_addr[2]) sh_v[cfg_addr[1:0]] <= cfg_wdata[VW-1:0];
      if (cfg_we && !cfg_addr[2]) sh_h[cfg_addr[1:0]] <= cfg_wdata[HW-1:0];
      if (tick) begin
        primed <= 1'b1;
        hpos <= nh;
        vpos <= nv;
        act_h <= na_h;
        act_v <= na_v;
        hsync <= hs_on ? HSYNC_POL : ~HSYNC_POL;
        vsync <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        display_on <= de;
        if (wrap) frame_count <= frame_count + 8'd1;
      end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: checks three timing generator configurations against a frame-arithmetic model
module tb_video_timing_gen;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic pend [NI];
  logic pt [NI];
  logic hs [NI];
  logic vs [NI];
  logic de [NI];
  logic ls [NI];
  logic fs [NI];
  logic [9:0] hp [NI];
  logic [9:0] vp [NI];
  logic [7:0] fc [NI];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  video_timing_gen #(.PIX_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1)) u0 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_pending(pend[0]), .pix_tick(pt[0]), .hpos(hp[0]), .vpos(vp[0]), .hsync(hs[0]), .vsync(vs[0]),
    .display_on(de[0]), .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0]));

  video_timing_gen #(.PIX_DIV(3), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1)) u1 (
    .clk(clk), .reset_n(reset_n), .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_wdata(12'd0),
    .cfg_pending(pend[1]), .pix_tick(pt[1]), .hpos(hp[1]), .vpos(vp[1]), .hsync(hs[1]), .vsync(vs[1]),
    .display_on(de[1]), .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1]));

  video_timing_gen #(.PIX_DIV(1), .HSYNC_POL(1'b1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(0), .H_BACK(1),
                     .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1)) u2 (
    .clk(clk), .reset_n(reset_n), .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_wdata(12'd0),
    .cfg_pending(pend[2]), .pix_tick(pt[2]), .hpos(hp[2]), .vpos(vp[2]), .hsync(hs[2]), .vsync(vs[2]),
    .display_on(de[2]), .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2]));

  // Model: pixel index k counted from the priming tick; position is the offset within the
  // current frame, split by the frame's line length. Frames end after h_total*v_total ticks.
  int m_c [NI];
  int m_base [NI];
  int m_h [NI];
  int m_v [NI];
  int m_fc [NI];
  int m_ah [NI][4];
  int m_av [NI][4];
  int m_sh [NI][4];
  int m_sv [NI][4];
  bit m_pend [NI];
  bit m_pt [NI];
  bit m_hs [NI];
  bit m_vs [NI];
  bit m_de [NI];
  bit m_ls [NI];
  bit m_fs [NI];

  function automatic int pd(int i);
    return i == 1 ? 3 : 1;
  endfunction

  function automatic bit hpol(int i);
    return i == 2;
  endfunction

  function automatic int tot_h(int i);
    return m_ah[i][0] + m_ah[i][1] + m_ah[i][2] + m_ah[i][3];
  endfunction

  function automatic int tot_v(int i);
    return m_av[i][0] + m_av[i][1] + m_av[i][2] + m_av[i][3];
  endfunction

  task automatic m_rst(int i);
    m_c[i] = 0;
    m_base[i] = 0;
    m_h[i] = 0;
    m_v[i] = 0;
    m_fc[i] = 0;
    for (int j = 0; j < 4; j++) begin
      m_ah[i][j] = j == 0 ? 4 : j == 2 ? (i == 2 ? 0 : 2) : 1;
      m_av[i][j] = j == 0 ? 3 : 1;
      m_sh[i][j] = m_ah[i][j];
      m_sv[i][j] = m_av[i][j];
    end
    m_pend[i] = 1'b0;
    m_pt[i] = 1'b0;
    m_hs[i] = !hpol(i);
    m_vs[i] = 1'b1;
    m_de[i] = 1'b0;
    m_ls[i] = 1'b0;
    m_fs[i] = 1'b0;
  endtask

  task automatic m_edge(int i);
    int k;
    int r;
    int ht;
    int hs0;
    int vs0;
    m_c[i]++;
    m_ls[i] = 1'b0;
    m_fs[i] = 1'b0;
    m_pt[i] = (m_c[i] % pd(i)) == 0;
    if (m_pt[i]) begin
      k = m_c[i] / pd(i) - 1;
      if (k == 0) m_base[i] = 0;
      if (k > 0 && k - m_base[i] == tot_h(i) * tot_v(i)) begin
        m_base[i] = k;
        for (int j = 0; j < 4; j++) begin
          m_ah[i][j] = m_sh[i][j];
          m_av[i][j] = m_sv[i][j];
        end
        m_pend[i] = 1'b0;
        m_fc[i] = (m_fc[i] + 1) % 256;
      end
      r = k - m_base[i];
      ht = tot_h(i);
      m_h[i] = r % ht;
      m_v[i] = r / ht;
      m_ls[i] = m_h[i] == 0;
      m_fs[i] = r == 0;
      hs0 = m_ah[i][0] + m_ah[i][1];
      vs0 = m_av[i][0] + m_av[i][1];
      m_hs[i] = (m_h[i] >= hs0 && m_h[i] < hs0 + m_ah[i][2]) ? hpol(i) : !hpol(i);
      m_vs[i] = (m_v[i] >= vs0 && m_v[i] < vs0 + m_av[i][2]) ? 1'b0 : 1'b1;
      m_de[i] = m_h[i] < m_ah[i][0] && m_v[i] < m_av[i][0];
    end
    if (i == 0 && cfg_we) begin
      if (!cfg_addr[2]) m_sh[0][cfg_addr[1:0]] = int'(cfg_wdata[9:0]);
      else m_sv[0][cfg_addr[1:0]] = int'(cfg_wdata[9:0]);
      m_pend[0] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < NI; i++)
      if (!reset_n) m_rst(i);
      else m_edge(i);

  task automatic cmp_model();
    logic [34:0] a;
    logic [34:0] x;
    for (int i = 0; i < NI; i++) begin
      a = {pend[i], pt[i], hs[i], vs[i], de[i], ls[i], fs[i], hp[i], vp[i], fc[i]};
      x = {m_pend[i], m_pt[i], m_hs[i], m_vs[i], m_de[i], m_ls[i], m_fs[i],
           10'(m_h[i]), 10'(m_v[i]), 8'(m_fc[i])};
      n_chk++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL model u%0d {pend,tick,hs,vs,de,ls,fs,h,v,fc}: got %h expected %h at %0t", i, a, x, $time);
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic wr(logic [2:0] a, logic [11:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_pos(int h, int v, int lim, string nm);
    int n = 0;
    while (!(int'(hp[0]) == h && (v < 0 || int'(vp[0]) == v)) && n < lim) begin
      step();
      n++;
    end
    chk(nm, int'(n < lim), 1);
  endtask

  task automatic wait_fs(int lim, string nm);
    int n = 0;
    while (!fs[0] && n < lim) begin
      step();
      n++;
    end
    chk(nm, int'(n < lim), 1);
  endtask

  initial begin
    int fs_u0 = 0;
    int hs_u2 = 0;
    int pt_u1 = 0;
    int fs1a = -1;
    int fs1b = -1;
    #2 reset_n = 1'b0;
    repeat (3) step();
    chk("reset hpos", hp[0], 0);
    chk("reset hsync", hs[0], 1);
    chk("reset vsync", vs[0], 1);
    chk("reset pix_tick", pt[0], 0);
    chk("reset hsync pol1", hs[2], 0);
    reset_n = 1'b1;
    for (int e = 1; e <= 150; e++) begin
      step();
      fs_u0 += int'(fs[0]);
      hs_u2 += int'(hs[2]);
      pt_u1 += int'(pt[1]);
      if (fs[1] && fs1a < 0) fs1a = e;
      else if (fs[1] && fs1b < 0) fs1b = e;
      if (e == 1) begin
        chk("prime hpos", hp[0], 0);
        chk("prime line_start", ls[0], 1);
        chk("prime frame_start", fs[0], 1);
        chk("prime frame_count", fc[0], 0);
        chk("prime display_on", de[0], 1);
        chk("div tick low e1", pt[1], 0);
      end
      if (e == 3) begin
        chk("div tick e3", pt[1], 1);
        chk("div prime fs", fs[1], 1);
      end
      if (e == 4) begin
        chk("div fs width", fs[1], 0);
        chk("div hpos hold", hp[1], 0);
        chk("display hpos3", de[0], 1);
      end
      if (e == 5) begin
        chk("hsync hpos4", hs[0], 1);
        chk("display hpos4", de[0], 0);
      end
      if (e == 6) begin
        chk("hsync hpos5", hs[0], 0);
        chk("pol1 hsync hpos5", hs[2], 0);
      end
      if (e == 7) chk("hsync hpos6", hs[0], 0);
      if (e == 8) chk("hsync hpos7", hs[0], 1);
      if (e == 25) chk("display vpos3", de[0], 0);
      if (e == 33) chk("vsync vpos4", vs[0], 0);
      if (e == 40) chk("vsync vpos4 end", vs[0], 0);
      if (e == 41) chk("vsync vpos5", vs[0], 1);
      if (e == 49) begin
        chk("2nd frame_start", fs[0], 1);
        chk("frame_count 1", fc[0], 1);
        chk("wrap vpos", vp[0], 0);
      end
    end
    chk("frame_start count", fs_u0, 4);
    chk("frame_count e150", fc[0], 3);
    chk("pol1 hsync highs", hs_u2, 0);
    chk("div tick count", pt_u1, 50);
    chk("div frame period", fs1b - fs1a, 144);
    wr(3'd0, 12'd6);
    chk("apply pending set", pend[0], 1);
    chk("apply old timing", hp[0], 6);
    wait_fs(100, "apply wait");
    chk("apply pending clear", pend[0], 0);
    repeat (9) step();
    chk("apply hpos9", hp[0], 9);
    step();
    chk("apply wrap hpos", hp[0], 0);
    chk("apply line_start", ls[0], 1);
    wait_pos(9, 5, 200, "collision wait");
    wr(3'd2, 12'd3);
    chk("collision frame_start", fs[0], 1);
    chk("collision pending", pend[0], 1);
    wait_pos(8, -1, 20, "collision hpos8 wait");
    chk("collision old sync hpos8", hs[0], 0);
    step();
    chk("collision old sync hpos9", hs[0], 1);
    wait_fs(200, "collision apply wait");
    chk("collision pending clear", pend[0], 0);
    wait_pos(9, -1, 20, "new sync wait");
    chk("new sync hpos9", hs[0], 0);
    step();
    chk("new h_max hpos10", hp[0], 10);
    chk("new sync hpos10", hs[0], 1);
    wait_pos(5, 2, 200, "reset position wait");
    #1 reset_n = 1'b0;
    #1 cmp_model();
    chk("async hpos", hp[0], 0);
    chk("async vpos", vp[0], 0);
    chk("async hsync", hs[0], 1);
    chk("async frame_count", fc[0], 0);
    chk("async pix_tick", pt[0], 0);
    chk("async display_on", de[0], 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("reprime hpos", hp[0], 0);
    chk("reprime line_start", ls[0], 1);
    chk("reprime frame_start", fs[0], 1);
    chk("reprime frame_count", fc[0], 0);
    repeat (7) step();
    chk("reset cfg hpos7", hp[0], 7);
    step();
    chk("reset cfg wrap", hp[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the 8-bit video path. It produces pixel/line counters, sync pulses of selectable polarity, a display-enable flag and line/frame strobes. Timing is held in eight run-time programmable registers, shadowed and applied only at frame boundaries. An internal pixel-clock divider lets one system clock drive several video modes. It sits between the clock/reset block and the pixel pipelines that consume `hpos`/`vpos`.

## Interface
- `HW`, 10: horizontal counter width.
- `VW`, 10: vertical counter width.
- `CW`, 12: `cfg_wdata` width; values are truncated to `HW` or `VW`.
- `PIX_DIV`, 1: system clocks per pixel; must be at least 1.
- `HSYNC_POL`, 0: active level of `hsync`.
- `VSYNC_POL`, 0: active level of `vsync`.
- `H_DISPLAY`/`H_FRONT`/`H_SYNC`/`H_BACK`, 256/7/23/23: reset timing values.
- `V_DISPLAY`/`V_BOTTOM`/`V_SYNC`/`V_TOP`, 240/14/4/4: reset timing values.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: shadow register write strobe.
- `cfg_addr` in 3: register select. 0 H_DISPLAY, 1 H_FRONT, 2 H_SYNC, 3 H_BACK, 4 V_DISPLAY, 5 V_BOTTOM, 6 V_SYNC, 7 V_TOP.
- `cfg_wdata` in CW: write data.
- `cfg_pending` out 1: shadow differs from active (written, not yet applied).
- `pix_tick` out 1: pixel-rate enable.
- `hpos` out HW, `vpos` out VW: current pixel position.
- `hsync` out 1, `vsync` out 1: sync outputs, polarity applied.
- `display_on` out 1: current pixel is visible.
- `line_start` out 1, `frame_start` out 1: one-clock strobes.
- `frame_count` out 8: frame counter, wraps at 255 to 0.

## Operation
- **Divider:** counts 0..PIX_DIV-1. `pix_tick` is high when the count equals PIX_DIV-1; it is constantly high when PIX_DIV=1. All position state changes only on clocks where `pix_tick`=1.
- **Derived values (active registers):**
  - h_max = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1, modulo 2^HW.
  - hs_start = H_DISPLAY+H_FRONT.
  - hs_end = hs_start+H_SYNC-1.
  - Vertical values are derived the same way (V_BOTTOM takes the place of H_FRONT, V_TOP of H_BACK).
  - Totals must fit in HW/VW bits. This is the programmer's responsibility; there is no overflow detection.
- **Counting:** on each tick, hpos increments. At hpos==h_max it wraps to 0 and vpos increments. At vpos==v_max it also wraps to 0 (the frame wrap).
- **Sync and display:**
  - hsync is active when hs_start ≤ hpos ≤ hs_end. H_SYNC=0 means hsync is never active.
  - vsync is defined the same way on vpos.
  - display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- **Strobes:**
  - `line_start` pulses for the clock on which hpos becomes 0.
  - `frame_start` pulses when both hpos and vpos become 0.
  - `frame_count` increments together with `frame_start`, except on the priming tick.
- **Shadow registers:**
  - A `cfg_we` write updates the shadow register and sets `cfg_pending`.
  - On the frame-wrap tick, active ← shadow and `cfg_pending` clears.
  - A write in the same clock as the wrap lands in the shadow only. The copy uses the pre-write shadow and `cfg_pending` stays 1.
  - `cfg_addr` decode uses all 3 bits; every address is valid.
- **Reset (asynchronous assert):**
  - Shadow and active registers load the parameter values.
  - Divider = 0, hpos = vpos = 0, frame_count = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - display_on, line_start, frame_start, cfg_pending, pix_tick = 0.
  - Reset mid-frame abandons the frame; there is no partial-frame completion.
- **Priming:** the first tick after `reset_n` deasserts is the priming tick.
  - hpos/vpos stay at 0 and frame_count stays at 0.
  - `line_start` and `frame_start` pulse.
  - hsync, vsync and display_on take their (0,0) values.
  - Normal counting starts on the next tick.

## Timing
- hpos, vpos, hsync, vsync, display_on, line_start and frame_start are all registered. They update on the same clock edge, so the sync and display outputs always describe the hpos/vpos being presented: zero skew, no one-pixel lag.
- Between ticks all outputs hold, except the strobes, which last exactly one clock.
- `pix_tick` is registered and high for one clock per pixel. It first goes high PIX_DIV clocks after reset deassertion.
- A new configuration takes effect on the tick that presents (0,0) of the next frame. `cfg_pending` falls on that same edge.
- `cfg_pending` rises on the clock after the write.

## Test plan
- **Small mode:** PIX_DIV=1; H = 4,1,2,1 (h_max 7); V = 3,1,1,1 (v_max 5).
  - Required: hsync active exactly at hpos 5–6.
  - vsync active for the whole of vpos 4.
  - display_on high only for hpos 0–3 with vpos 0–2.
  - frame_start every 48 clocks; frame_count = 1 after the second frame_start.
- **Divider:** PIX_DIV=3 with the small mode. Required: pix_tick every 3rd clock; hpos holds for 3 clocks; frame period is 144 clocks; strobes are 1 clock wide.
- **Shadow apply:** mid-frame, write addr0 = 6. Required: cfg_pending=1; timing unchanged until the wrap; after the next frame_start, h_max = 9 and cfg_pending=0.
- **Collision:** write addr2 = 3 in the same clock as the frame-wrap tick. Required: old H_SYNC stays active for the new frame; cfg_pending stays 1; the value applies at the following wrap.
- **Polarity and zero sync:** HSYNC_POL=1, H_SYNC=0. Required: hsync stays 0 for the entire frame; vsync is low-active per VSYNC_POL=0.
- **Async reset mid-frame:** assert reset_n low between clock edges at hpos=5, vpos=2. Required: outputs immediately take their reset values. After release, the priming tick presents (0,0) with line_start=frame_start=1 and frame_count=0.
